// File: rtl/timer_scheduler_pkg.sv
// timer_scheduler_pkg: shared types and helpers for the timer scheduler.
//   state_t   - scheduler FSM state encoding
//   rr_pick_t - round-robin pick result (valid + index)
//   rr_pick() - first set request at or above ptr, wrapping at num_req
package timer_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    RUN  = 2'b10,
    DONE = 2'b11
  } state_t;

  // Widest supported requester set; callers zero-extend into these widths.
  localparam int unsigned MAX_REQ  = 16;
  localparam int unsigned MAX_ID_W = 4;

  typedef struct packed {
    logic                valid;
    logic [MAX_ID_W-1:0] idx;
  } rr_pick_t;

  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0]  req,
                                       input logic [MAX_ID_W-1:0] ptr,
                                       input int unsigned         num_req);
    rr_pick_t    pick;
    int unsigned cand;
    pick = '0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      // ptr < num_req and i < num_req, so one subtraction is enough to wrap.
      cand = 32'(ptr) + i;
      if (cand >= num_req) cand = cand - num_req;
      if (i < num_req && !pick.valid && req[cand[MAX_ID_W-1:0]]) begin
        pick.valid = 1'b1;
        pick.idx   = cand[MAX_ID_W-1:0];
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/timer_scheduler_if.sv
// timer_scheduler_if: client-side bundle of the timer scheduler.
//   req     - per-requester request, held until done
//   dly     - flattened delays, requester i at [i*CNT_W +: CNT_W]
//   gnt     - one-hot grant, LOAD through DONE
//   done    - one-hot single-cycle completion pulse
//   busy    - scheduler not idle
//   cur_id  - current / last owner index
//   cnt_val - live shared counter value
// master = clients, slave = scheduler.
interface timer_scheduler_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned CNT_W   = 8
);
  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*CNT_W-1:0] dly;
  logic [NUM_REQ-1:0]       gnt;
  logic [NUM_REQ-1:0]       done;
  logic                     busy;
  logic [ID_W-1:0]          cur_id;
  logic [CNT_W-1:0]         cnt_val;

  modport master (output req, dly, input gnt, done, busy, cur_id, cnt_val);
  modport slave  (input req, dly, output gnt, done, busy, cur_id, cnt_val);
endinterface

// File: rtl/timer_scheduler_counter.sv
// counter: loadable up/down counter with wrap flag.
//   clk      - rising-edge clock
//   res_n    - asynchronous active-low reset
//   enable   - advance or load this cycle
//   load     - take cnt_in instead of stepping
//   dir      - 1 = down, 0 = up
//   cnt_in   - load value
//   cnt_out  - current count
//   overflow - registered carry/borrow of the last step
module counter #(
  parameter int unsigned counter_size = 8
) (
  input  logic                    clk,
  input  logic                    res_n,
  input  logic                    enable,
  input  logic                    load,
  input  logic                    dir,
  input  logic [counter_size-1:0] cnt_in,
  output logic [counter_size-1:0] cnt_out,
  output logic                    overflow
);
  logic [counter_size-1:0] cnt_q;
  logic                    ovf_q;
  logic [counter_size:0]   step_d;

  // Extra top bit captures borrow (down) or carry (up).
  always_comb begin
    step_d = dir ? ({1'b0, cnt_q} - (counter_size+1)'(1))
                 : ({1'b0, cnt_q} + (counter_size+1)'(1));
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (enable) begin
      if (load) begin
        cnt_q <= cnt_in;
        ovf_q <= 1'b0;
      end else begin
        cnt_q <= step_d[counter_size-1:0];
        ovf_q <= step_d[counter_size];
      end
    end
  end

  assign cnt_out  = cnt_q;
  assign overflow = ovf_q;
endmodule

// File: rtl/timer_scheduler.sv
// timer_scheduler: round-robin sharing of one down counter among NUM_REQ
// requesters. The owner's delay is loaded, counted to zero, and a one-cycle
// done pulse is returned to it.
//   clk - rising-edge clock
//   res - asynchronous active-high reset
//   bus - timer_scheduler_if.slave (req/dly in; gnt/done/busy/cur_id/cnt_val out)
module timer_scheduler
  import timer_scheduler_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned CNT_W   = 8
) (
  input  logic              clk,
  input  logic              res,
  timer_scheduler_if.slave  bus
);
  localparam int unsigned ID_W = $clog2(NUM_REQ);

  state_t             state_q;
  logic [ID_W-1:0]    ptr_q;
  logic [ID_W-1:0]    cur_id_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic [NUM_REQ-1:0] done_q;

  rr_pick_t           pick;
  logic [ID_W-1:0]    pick_id;
  logic [ID_W-1:0]    next_ptr;
  logic               owner_req;
  logic               cnt_en;
  logic               cnt_load;
  logic [CNT_W-1:0]   cnt_in;
  logic [CNT_W-1:0]   cnt_out;

  // Arbitration only matters in IDLE; elsewhere the pick is forced invalid.
  always_comb begin
    pick = '0;
    if (state_q == IDLE) begin
      pick = rr_pick(MAX_REQ'(bus.req), MAX_ID_W'(ptr_q), NUM_REQ);
    end
  end

  assign pick_id   = ID_W'(pick.idx);
  assign next_ptr  = (cur_id_q == ID_W'(NUM_REQ - 1)) ? '0 : cur_id_q + 1'b1;
  assign owner_req = bus.req[cur_id_q];
  assign cnt_in    = bus.dly[cur_id_q*CNT_W +: CNT_W];

  // Decrement is gated at zero so the counter never wraps in RUN.
  assign cnt_load = (state_q == LOAD);
  assign cnt_en   = cnt_load || ((state_q == RUN) && (cnt_out != '0));

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      cur_id_q <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
    end else begin
      done_q <= '0;
      case (state_q)
        IDLE: begin
          if (pick.valid) begin
            cur_id_q <= pick_id;
            gnt_q    <= NUM_REQ'(1) << pick_id;
            state_q  <= LOAD;
          end
        end
        LOAD: begin
          if (!owner_req) begin
            gnt_q   <= '0;
            ptr_q   <= next_ptr;
            state_q <= IDLE;
          end else begin
            state_q <= RUN;
          end
        end
        RUN: begin
          // Owner withdrawal wins over completion: no done on abort.
          if (!owner_req) begin
            gnt_q   <= '0;
            ptr_q   <= next_ptr;
            state_q <= IDLE;
          end else if (cnt_out == '0) begin
            done_q  <= gnt_q;
            state_q <= DONE;
          end
        end
        DONE: begin
          gnt_q   <= '0;
          ptr_q   <= next_ptr;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  counter #(
    .counter_size(CNT_W)
  ) u_counter (
    .clk      (clk),
    .res_n    (~res),
    .enable   (cnt_en),
    .load     (cnt_load),
    .dir      (1'b1),
    .cnt_in   (cnt_in),
    .cnt_out  (cnt_out),
    .overflow ()
  );

  assign bus.gnt     = gnt_q;
  assign bus.done    = done_q;
  assign bus.busy    = (state_q != IDLE);
  assign bus.cur_id  = cur_id_q;
  assign bus.cnt_val = cnt_out;

endmodule

// File: tb/tb_timer_scheduler.sv
// Scoreboard bench for timer_scheduler: stimulus queues expected grant and
// done events (vector + edge number); a negedge monitor pops and compares.
module tb_timer_scheduler;
  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned CNT_W   = 8;

  typedef struct {
    logic [NUM_REQ-1:0] vec;
    int unsigned        at;
  } exp_t;

  logic clk;
  logic res;
  int unsigned edge_cnt;
  int unsigned checks;
  int unsigned failures;
  exp_t exp_gnt[$];
  exp_t exp_done[$];

  timer_scheduler_if #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W)) bus ();

  timer_scheduler #(
    .NUM_REQ(NUM_REQ),
    .CNT_W  (CNT_W)
  ) dut (
    .clk(clk),
    .res(res),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input int unsigned act, input int unsigned req_v);
    checks++;
    if (act !== req_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, req_v, edge_cnt);
    end
  endtask

  task automatic push_gnt(input logic [NUM_REQ-1:0] v, input int unsigned at);
    exp_t e;
    e.vec = v; e.at = at;
    exp_gnt.push_back(e);
  endtask

  task automatic push_done(input logic [NUM_REQ-1:0] v, input int unsigned at);
    exp_t e;
    e.vec = v; e.at = at;
    exp_done.push_back(e);
  endtask

  task automatic set_dly(input int unsigned id, input logic [CNT_W-1:0] v);
    bus.dly[id*CNT_W +: CNT_W] = v;
  endtask

  // Returns at the negedge following edge e.
  task automatic wait_until(input int unsigned e);
    while (edge_cnt < e) @(negedge clk);
  endtask

  // Monitor: every rising grant and every done cycle must match the queue head.
  logic [NUM_REQ-1:0] prev_gnt;
  exp_t               me;
  initial prev_gnt = '0;
  always @(negedge clk) begin
    if (bus.gnt != '0 && prev_gnt == '0) begin
      if (exp_gnt.size() == 0) begin
        check("gnt_unexpected", 32'(bus.gnt), 0);
      end else begin
        me = exp_gnt.pop_front();
        check("gnt_vec", 32'(bus.gnt), 32'(me.vec));
        check("gnt_edge", edge_cnt, me.at);
      end
    end
    prev_gnt = bus.gnt;
    if (bus.done != '0) begin
      if (exp_done.size() == 0) begin
        check("done_unexpected", 32'(bus.done), 0);
      end else begin
        me = exp_done.pop_front();
        check("done_vec", 32'(bus.done), 32'(me.vec));
        check("done_edge", edge_cnt, me.at);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned k;
    checks = 0;
    failures = 0;
    res = 1'b1;
    bus.req = '0;
    bus.dly = '0;
    repeat (3) @(negedge clk);
    res = 1'b0;
    @(negedge clk);
    check("rst_gnt", 32'(bus.gnt), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_cur_id", 32'(bus.cur_id), 0);
    check("rst_cnt", 32'(bus.cnt_val), 0);

    // Requester 2, D=5: done 7 edges after sampling.
    set_dly(2, 8'd5);
    bus.req = 4'b0100;
    k = edge_cnt + 1;
    push_gnt(4'b0100, k);
    push_done(4'b0100, k + 7);
    wait_until(k);
    check("t1_gnt", 32'(bus.gnt), 4);
    check("t1_busy", 32'(bus.busy), 1);
    check("t1_cur_id", 32'(bus.cur_id), 2);
    for (int j = 0; j < 6; j++) begin
      wait_until(k + 1 + j);
      check("t1_cnt", 32'(bus.cnt_val), 5 - j);
    end
    wait_until(k + 7);
    bus.req = '0;
    wait_until(k + 9);
    check("t1_idle_busy", 32'(bus.busy), 0);
    check("t1_idle_gnt", 32'(bus.gnt), 0);
    check("t1_hold_cur_id", 32'(bus.cur_id), 2);

    // Requester 0, D=0 (ptr=3 wraps to 0).
    set_dly(0, 8'd0);
    bus.req = 4'b0001;
    k = edge_cnt + 1;
    push_gnt(4'b0001, k);
    push_done(4'b0001, k + 2);
    for (int j = 0; j < 3; j++) begin
      wait_until(k + j);
      check("t2_cnt", 32'(bus.cnt_val), 0);
    end
    bus.req = '0;
    wait_until(k + 4);

    // Reset so ptr=0, then all four continuously with D=2.
    res = 1'b1;
    @(negedge clk);
    res = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) set_dly(i, 8'd2);
    bus.req = 4'b1111;
    k = edge_cnt + 1;
    for (int g = 0; g < 5; g++) begin
      push_gnt(4'(1 << (g % 4)), k + 6 * g);
      push_done(4'(1 << (g % 4)), k + 6 * g + 4);
    end
    wait_until(k + 28);
    bus.req = '0;
    wait_until(k + 31);
    check("t3_idle_busy", 32'(bus.busy), 0);

    // ptr=1: requester 1, D=200, aborted at count 150.
    set_dly(1, 8'd200);
    bus.req = 4'b0010;
    k = edge_cnt + 1;
    push_gnt(4'b0010, k);
    wait_until(k + 51);
    check("t4_cnt150", 32'(bus.cnt_val), 150);
    bus.req = '0;
    wait_until(k + 52);
    check("t4_abort_busy", 32'(bus.busy), 0);
    check("t4_abort_gnt", 32'(bus.gnt), 0);
    check("t4_abort_done", 32'(bus.done), 0);
    // ptr must now be 2: of {1,3}, requester 3 wins.
    set_dly(3, 8'd1);
    bus.req = 4'b1010;
    k = edge_cnt + 1;
    push_gnt(4'b1000, k);
    push_done(4'b1000, k + 3);
    wait_until(k);
    bus.req = 4'b1000;
    wait_until(k + 3);
    bus.req = '0;
    wait_until(k + 5);

    // ptr=0: requester 2, D=6, async reset at count 3.
    set_dly(2, 8'd6);
    bus.req = 4'b0100;
    k = edge_cnt + 1;
    push_gnt(4'b0100, k);
    wait_until(k + 4);
    check("t5_cnt3", 32'(bus.cnt_val), 3);
    #2 res = 1'b1;
    #1;
    check("t5_rst_gnt", 32'(bus.gnt), 0);
    check("t5_rst_done", 32'(bus.done), 0);
    check("t5_rst_busy", 32'(bus.busy), 0);
    check("t5_rst_cur_id", 32'(bus.cur_id), 0);
    check("t5_rst_cnt", 32'(bus.cnt_val), 0);
    bus.req = 4'b1000;
    set_dly(3, 8'd1);
    @(negedge clk);
    @(negedge clk);
    res = 1'b0;
    k = edge_cnt + 1;
    push_gnt(4'b1000, k);
    push_done(4'b1000, k + 3);
    wait_until(k + 3);
    bus.req = '0;
    wait_until(k + 5);

    // ptr=0: requester 0, D=10; delay rewritten to 50 mid-run is ignored.
    set_dly(0, 8'd10);
    bus.req = 4'b0001;
    k = edge_cnt + 1;
    push_gnt(4'b0001, k);
    push_done(4'b0001, k + 12);
    wait_until(k + 4);
    check("t6_cnt7", 32'(bus.cnt_val), 7);
    set_dly(0, 8'd50);
    wait_until(k + 5);
    check("t6_cnt6", 32'(bus.cnt_val), 6);
    wait_until(k + 12);
    bus.req = '0;
    wait_until(k + 15);

    check("gnt_queue_empty", exp_gnt.size(), 0);
    check("done_queue_empty", exp_done.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
